// File: rtl/alu32_out_stage.sv
// -----------------------------------------------------------------------------
// alu32_out_stage
//
// Registered output stage sitting directly after the 32-bit ALU. The ALU's
// combinational result, opcode and {c,n,z,v} flags are captured into a
// 2-entry skid buffer. The buffer has valid/ready handshakes on both sides, so
// the next stage can stall without any result being lost. The stage also
// counts retired operations and, when built with the sticky feature, ORs the
// flags of every retired operation into a sticky register.
//
// Build option:
//   ALU32_OUT_STICKY_EN  when defined, builds the sticky-flag register.
//                        When undefined, sticky_flags is tied to 0 and
//                        sticky_clr is ignored.
//
// Parameters:
//   CNT_W        width of op_count (default 16)
//
// Ports:
//   clk          in   rising-edge clock, sole clock
//   reset        in   synchronous, active-high reset
//   in_valid     in   ALU result/op/flags valid this cycle
//   in_ready     out  stage can accept (registered: state != FULL)
//   in_op        in   [2:0]  ALU opcode
//   in_result    in   [31:0] ALU result
//   in_flags     in   [3:0]  {c,n,z,v}
//   out_valid    out  head entry valid (registered: state != EMPTY)
//   out_ready    in   consumer accepts head entry
//   out_op       out  [2:0]  head opcode
//   out_result   out  [31:0] head result
//   out_flags    out  [3:0]  head {c,n,z,v}
//   op_count     out  [CNT_W-1:0] output handshakes, wraps silently
//   sticky_clr   in   clear sticky_flags
//   sticky_flags out  [3:0]  OR of retired flags since last clear
//   state_dbg    out  [1:0]  occupancy FSM state (0 EMPTY, 1 ONE, 2 FULL)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised the sender holds its payload stable until
// the transfer happens; ready may be raised or dropped at any time.
// On this block both in_ready and out_valid are pure functions of the state
// register, so neither depends combinationally on the opposite side.
// -----------------------------------------------------------------------------
module alu32_out_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_result,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_op,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] op_count,
  input  logic             sticky_clr,
  output logic [3:0]       sticky_flags,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;

  // Second entry: only meaningful in FULL, where it holds the word that
  // arrived while the head was stalled.
  logic [2:0]  skid_op;
  logic [31:0] skid_result;
  logic [3:0]  skid_flags;

  logic push;
  logic pop;

  // Load controls for the head and skid registers.
  logic head_from_in;
  logic head_from_skid;
  logic skid_from_in;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign state_dbg = state;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    head_from_in   = 1'b0;
    head_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          state_nxt    = ST_ONE;
          head_from_in = 1'b1;
        end
      end
      ST_ONE: begin
        case ({push, pop})
          2'b10: begin
            state_nxt    = ST_FULL;
            skid_from_in = 1'b1;
          end
          2'b01: begin
            // Head keeps its value so out_* hold while out_valid is low.
            state_nxt = ST_EMPTY;
          end
          2'b11: begin
            // Simultaneous push and pop: the new word replaces the head
            // directly, so there is no bubble.
            head_from_in = 1'b1;
          end
          default: begin
            state_nxt = ST_ONE;
          end
        endcase
      end
      ST_FULL: begin
        if (pop) begin
          state_nxt      = ST_ONE;
          head_from_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // The head registers drive out_* directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_op     <= 3'b0;
      out_result <= 32'b0;
      out_flags  <= 4'b0;
    end else if (head_from_in) begin
      out_op     <= in_op;
      out_result <= in_result;
      out_flags  <= in_flags;
    end else if (head_from_skid) begin
      out_op     <= skid_op;
      out_result <= skid_result;
      out_flags  <= skid_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_op     <= 3'b0;
      skid_result <= 32'b0;
      skid_flags  <= 4'b0;
    end else if (skid_from_in) begin
      skid_op     <= in_op;
      skid_result <= in_result;
      skid_flags  <= in_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

`ifdef ALU32_OUT_STICKY_EN
  // A clear and a pop in the same cycle leave only the popped flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_flags <= 4'b0;
    end else begin
      sticky_flags <= (sticky_clr ? 4'b0 : sticky_flags) |
                      (pop ? out_flags : 4'b0);
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = 4'b0;
`endif

endmodule

// File: tb/tb_alu32_out_stage.sv
// -----------------------------------------------------------------------------
// tb_alu32_out_stage
//
// Bench for alu32_out_stage. A queue-based reference model tracks the
// buffered words, the retired-operation count and the sticky flags; a compare
// process checks every DUT output against it on each falling edge. Directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_alu32_out_stage;

  localparam int CNT_W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = 3'b0;
  logic [31:0]      in_result = 32'b0;
  logic [3:0]       in_flags = 4'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       out_op;
  logic [31:0]      out_result;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] op_count;
  logic             sticky_clr = 1'b0;
  logic [3:0]       sticky_flags;
  logic [1:0]       state_dbg;

  alu32_out_stage #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .op_count     (op_count),
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
    .state_dbg    (state_dbg)
  );

  // scoreboard
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference model: entry = {op, result, flags}
  logic [38:0] exp_q[$];
  logic [38:0] m_hold = '0;
  logic [3:0]  m_sticky = 4'b0;
  int          m_count = 0;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    logic [38:0] popped;
    bit m_push, m_pop;
    if (reset) begin
      exp_q.delete();
      m_hold   = '0;
      m_sticky = 4'b0;
      m_count  = 0;
      m_init   = 1'b1;
    end else if (m_init) begin
      m_push = in_valid && (exp_q.size() < 2);
      m_pop  = out_ready && (exp_q.size() > 0);
      popped = '0;
      if (m_pop) begin
        popped = exp_q.pop_front();
        m_count++;
      end
`ifdef ALU32_OUT_STICKY_EN
      m_sticky = (sticky_clr ? 4'b0 : m_sticky) | popped[3:0];
`else
      m_sticky = 4'b0;
`endif
      if (m_push) exp_q.push_back({in_op, in_result, in_flags});
      if (exp_q.size() > 0) m_hold = exp_q[0];
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("state", state_dbg, exp_q.size());
      chk("out_op", out_op, m_hold[38:36]);
      chk("out_result", out_result, m_hold[35:4]);
      chk("out_flags", out_flags, m_hold[3:0]);
      chk("op_count", op_count, m_count % (1 << CNT_W));
      chk("sticky_flags", sticky_flags, m_sticky);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                       input logic [3:0] fl);
    in_valid  = v;
    in_op     = op;
    in_result = res;
    in_flags  = fl;
  endtask

  initial begin
    int base;
    int n;

    // reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_op_count", op_count, 0);
    chk("rst_out_result", out_result, 0);

    // 1: single word through an empty buffer
    out_ready = 1'b1;
    drive(1'b1, 3'b110, 32'h5, 4'b0000);
    tick();
    drive(1'b0, 3'b0, 32'h0, 4'b0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_result", out_result, 32'h5);
    chk("t1_op", out_op, 3'b110);
    tick();
    chk("t1_count", op_count, 1);
    chk("t1_empty", state_dbg, 2'd0);

    // 2: stall with three words offered
    base = 1;
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 32'h1, 4'b0001);
    tick();
    drive(1'b1, 3'b010, 32'h2, 4'b0010);
    tick();
    drive(1'b1, 3'b011, 32'h3, 4'b0011);
    chk("t2_in_ready_full", in_ready, 1'b0);
    tick();
    tick();
    chk("t2_head_A", out_result, 32'h1);
    chk("t2_still_full", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("t2_head_B", out_result, 32'h2);
    tick();
    drive(1'b0, 3'b0, 32'h0, 4'b0);
    chk("t2_head_C", out_result, 32'h3);
    tick();
    chk("t2_count", op_count, base + 3);
    chk("t2_empty", out_valid, 1'b0);

    // 3: simultaneous push and pop in ONE
    out_ready = 1'b0;
    drive(1'b1, 3'b100, 32'd10, 4'b0100);
    tick();
    chk("t3_head10", out_result, 32'd10);
    drive(1'b1, 3'b101, 32'd20, 4'b1000);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 3'b0, 32'h0, 4'b0);
    chk("t3_state_one", state_dbg, 2'd1);
    chk("t3_head20", out_result, 32'd20);
    chk("t3_valid", out_valid, 1'b1);
    tick();

    // 4: op_count wrap
    n = 65535 - (m_count % 65536);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 3'(i), 32'(i * 7 + 3), 4'(i));
      tick();
    end
    drive(1'b0, 3'b0, 32'h0, 4'b0);
    tick();
    chk("t4_max", op_count, 16'hFFFF);
    drive(1'b1, 3'b111, 32'hDEAD_BEEF, 4'b1111);
    tick();
    drive(1'b0, 3'b0, 32'h0, 4'b0);
    tick();
    chk("t4_wrap", op_count, 16'h0000);
    chk("t4_hold_result", out_result, 32'hDEAD_BEEF);

    // 5: sticky flags
    out_ready = 1'b1;
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    drive(1'b1, 3'b000, 32'hA, 4'b1000);
    tick();
    drive(1'b1, 3'b000, 32'hB, 4'b0010);
    tick();
    drive(1'b0, 3'b0, 32'h0, 4'b0);
    tick();
`ifdef ALU32_OUT_STICKY_EN
    chk("t5_sticky_or", sticky_flags, 4'b1010);
`else
    chk("t5_sticky_off", sticky_flags, 4'b0000);
`endif
    drive(1'b1, 3'b000, 32'hC, 4'b0100);
    tick();
    drive(1'b0, 3'b0, 32'h0, 4'b0);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
`ifdef ALU32_OUT_STICKY_EN
    chk("t5_sticky_clr_pop", sticky_flags, 4'b0100);
`else
    chk("t5_sticky_off2", sticky_flags, 4'b0000);
`endif

    // 6: reset while FULL with both handshakes asserted
    out_ready = 1'b0;
    drive(1'b1, 3'b011, 32'h1234_5678, 4'b1111);
    tick();
    drive(1'b1, 3'b101, 32'h8765_4321, 4'b0110);
    tick();
    chk("t6_full", state_dbg, 2'd2);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 3'b0, 32'h0, 4'b0);
    chk("t6_state", state_dbg, 2'd0);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_count", op_count, 0);
    chk("t6_result", out_result, 0);
    chk("t6_op", out_op, 0);
    chk("t6_flags", out_flags, 0);
    chk("t6_sticky", sticky_flags, 0);
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
